// File: rtl/arm_pkg.sv
// Shared definitions for the IF stage: word geometry, boot address and fetch FSM states.
package arm_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [WORD_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous in-order FIFO holding {pc+4, instr} entries for the ID stage.
// Flush empties the queue and wins over push/pop in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH_L);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next pointer/count values; a push into a full queue is only taken when a pop frees a slot.
    always_comb begin
        do_pop   = pop_i && !empty_o && !flush_i;
        do_push  = push_i && !flush_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed while the queue is non-empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/if_fetch_controller.sv
// IF-stage fetch sequencer: owns the PC, issues word fetches, tracks in-flight requests,
// queues returned instructions for ID and discards stale responses after a branch redirect.
module if_fetch_controller #(
    parameter int                ADDR_W   = arm_pkg::WORD_W,
    parameter int                DATA_W   = arm_pkg::WORD_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(arm_pkg::RESET_PC),
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              if_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_instr_o
);

    import arm_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]    DEPTH_L = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);

    fetch_state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic                     q_push, q_pop, q_flush, q_full, q_empty;
    logic [CNT_W-1:0]         q_count;
    logic [ADDR_W+DATA_W-1:0] q_wdata, q_rdata;
    logic [CNT_W:0]           inflight_total;
    logic                     rsp_valid, issue;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (q_flush),
        .wdata_i (q_wdata),
        .rdata_o (q_rdata),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign imem_addr_o = pc_q;
    assign if_valid_o  = !q_empty;
    assign if_pc_o     = q_empty ? '0 : q_rdata[ADDR_W+DATA_W-1:DATA_W];
    assign if_instr_o  = q_empty ? '0 : q_rdata[DATA_W-1:0];

    // Request gating, response routing (drop vs. push) and redirect handling.
    // rsp_pc tracks the address of the next response that will actually be kept;
    // responses seen with nothing outstanding (e.g. left over from before a reset) are ignored.
    always_comb begin
        rsp_valid      = imem_rvalid_i && (outstanding_q != '0);
        inflight_total = {1'b0, outstanding_q} + {1'b0, q_count};
        imem_req_o     = (state_q != BOOT) && !freeze_i && !branch_taken_i
                         && (inflight_total < DEPTH_L);
        issue          = imem_req_o && imem_gnt_i;

        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        q_push        = 1'b0;
        q_pop         = 1'b0;
        q_flush       = 1'b0;
        q_wdata       = {rsp_pc_q + STEP, imem_rdata_i};

        if (branch_taken_i) begin
            pc_d          = branch_addr_i & ~ADDR_W'(3);
            rsp_pc_d      = branch_addr_i & ~ADDR_W'(3);
            q_flush       = 1'b1;
            outstanding_d = outstanding_q - CNT_W'(rsp_valid);
            discard_d     = outstanding_q - CNT_W'(rsp_valid);
        end else begin
            if (issue) begin
                pc_d = pc_q + STEP;
            end
            if (rsp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                end else begin
                    q_push   = 1'b1;
                    rsp_pc_d = rsp_pc_q + STEP;
                end
            end
            outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp_valid);
            q_pop         = if_valid_o && id_ready_i;
        end
    end

    // Fetch FSM next state: leave BOOT after one clock, sit in DRAIN while stale responses remain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (branch_taken_i && (discard_d != '0)) state_d = DRAIN;
            DRAIN:   if (!branch_taken_i && (discard_d == '0)) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // PC, response tracking, counters and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // The capacity rule keeps the queue from ever receiving a response while full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_if_fetch_controller.sv
// Directed bench for if_fetch_controller with a simple in-order memory model
// that answers each request after mem_lat cycles with (address + data_tag).
module tb_if_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        freeze_i;
    logic        branch_taken_i;
    logic [31:0] branch_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        id_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    int n_checks = 0;
    int n_fail   = 0;

    int          mem_lat  = 1;
    logic [31:0] data_tag = '0;
    int          ecnt     = 0;
    logic [31:0] pend_data[$];
    int          pend_due[$];
    logic [31:0] issued[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];

    if_fetch_controller #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .freeze_i       (freeze_i),
        .branch_taken_i (branch_taken_i),
        .branch_addr_i  (branch_addr_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .if_valid_o     (if_valid_o),
        .id_ready_i     (id_ready_i),
        .if_pc_o        (if_pc_o),
        .if_instr_o     (if_instr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record issued requests and ID-side pops at each rising edge (pre-update values).
    always @(posedge clk) begin
        ecnt = ecnt + 1;
        if (rst_n && imem_req_o && imem_gnt_i) begin
            issued.push_back(imem_addr_o);
            pend_data.push_back(imem_addr_o + data_tag);
            pend_due.push_back(ecnt + mem_lat);
        end
        if (rst_n && if_valid_o && id_ready_i && !branch_taken_i) begin
            pop_pc.push_back(if_pc_o);
            pop_instr.push_back(if_instr_o);
        end
    end

    // Present the oldest due response for the coming rising edge.
    always @(negedge clk) begin
        if (pend_due.size() > 0 && pend_due[0] <= ecnt + 1) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = pend_data[0];
            void'(pend_due.pop_front());
            void'(pend_data.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        freeze_i       = 1'b0;
        branch_taken_i = 1'b0;
        branch_addr_i  = '0;
        id_ready_i     = 1'b0;
        imem_gnt_i     = 1'b0;
        data_tag       = '0;
        pend_due.delete();
        pend_data.delete();
        step();
        step();
        issued.delete();
        pop_pc.delete();
        pop_instr.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pop_pc.size() < n && k < budget) begin
            step();
            k++;
        end
        if (pop_pc.size() < n) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: got %0d pops, required %0d", name, pop_pc.size(), n);
        end
    endtask

    task automatic wait_issued(input int n, input int budget, input string name);
        int k = 0;
        while (issued.size() < n && k < budget) begin
            step();
            k++;
        end
        if (issued.size() < n) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: got %0d issues, required %0d", name, issued.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        freeze_i       = 1'b0;
        branch_taken_i = 1'b0;
        branch_addr_i  = '0;
        id_ready_i     = 1'b0;
        imem_gnt_i     = 1'b0;
        step();
        n_checks++;
        if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %0b, expected 0", imem_req_o); end
        n_checks++;
        if (imem_addr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h, expected 0", imem_addr_o); end
        n_checks++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b, expected 0", if_valid_o); end
        n_checks++;
        if (if_pc_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h, expected 0", if_pc_o); end
        n_checks++;
        if (if_instr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h, expected 0", if_instr_o); end
        imem_gnt_i = 1'b1;
        rst_n      = 1'b1;
        #1;
        n_checks++;
        if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_req: got %0b, expected 0", imem_req_o); end
        step();
        n_checks++;
        if (imem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL run_req: got %0b, expected 1", imem_req_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
        logic [31:0] exp_in [3] = '{32'h0, 32'h4, 32'h8};
        do_reset();
        mem_lat    = 1;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
        wait_pops(3, 40, "seq");
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= issued.size() || issued[i] !== exp_in[i]) begin
                n_fail++; $display("[TB] FAIL seq_addr[%0d]: got %h, expected %h", i, issued[i], exp_in[i]);
            end
            n_checks++;
            if (i >= pop_pc.size() || pop_pc[i] !== exp_pc[i]) begin
                n_fail++; $display("[TB] FAIL seq_pc[%0d]: got %h, expected %h", i, pop_pc[i], exp_pc[i]);
            end
            n_checks++;
            if (i >= pop_instr.size() || pop_instr[i] !== exp_in[i]) begin
                n_fail++; $display("[TB] FAIL seq_instr[%0d]: got %h, expected %h", i, pop_instr[i], exp_in[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_lat    = 1;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b0;
        repeat (10) step();
        n_checks++;
        if (issued.size() !== 2) begin n_fail++; $display("[TB] FAIL bp_issued: got %0d, expected 2", issued.size()); end
        n_checks++;
        if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_req: got %0b, expected 0", imem_req_o); end
        n_checks++;
        if (if_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid: got %0b, expected 1", if_valid_o); end
        n_checks++;
        if (if_pc_o !== 32'h4) begin n_fail++; $display("[TB] FAIL bp_head_pc: got %h, expected 4", if_pc_o); end
        id_ready_i = 1'b1;
        wait_pops(4, 40, "bp");
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= pop_pc.size() || pop_pc[i] !== 32'(4 * i + 4) || pop_instr[i] !== 32'(4 * i)) begin
                n_fail++;
                $display("[TB] FAIL bp_order[%0d]: got pc %h instr %h, expected pc %h instr %h",
                         i, pop_pc[i], pop_instr[i], 32'(4 * i + 4), 32'(4 * i));
            end
        end
    endtask

    task automatic test_freeze();
        int k = 0;
        int n0;
        do_reset();
        mem_lat    = 1;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
        while (imem_addr_o !== 32'h10 && k < 30) begin
            step();
            k++;
        end
        if (imem_addr_o !== 32'h10) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL frz_reach_timeout: got addr %h, required 10", imem_addr_o);
        end
        freeze_i = 1'b1;
        n0 = issued.size();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (imem_addr_o !== 32'h10) begin n_fail++; $display("[TB] FAIL frz_addr[%0d]: got %h, expected 10", i, imem_addr_o); end
            n_checks++;
            if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL frz_req[%0d]: got %0b, expected 0", i, imem_req_o); end
        end
        n_checks++;
        if (issued.size() !== n0) begin n_fail++; $display("[TB] FAIL frz_no_issue: got %0d, expected %0d", issued.size(), n0); end
        n_checks++;
        if (pop_pc.size() !== 4 || pop_pc[3] !== 32'h10) begin
            n_fail++; $display("[TB] FAIL frz_drain: got %0d pops last pc %h, expected 4 pops last pc 10", pop_pc.size(), pop_pc[pop_pc.size()-1]);
        end
        n_checks++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL frz_empty: got %0b, expected 0", if_valid_o); end
        freeze_i = 1'b0;
        wait_pops(5, 20, "frz_resume");
        n_checks++;
        if (pop_pc.size() < 5 || pop_pc[4] !== 32'h14 || pop_instr[4] !== 32'h10) begin
            n_fail++; $display("[TB] FAIL frz_resume: got pc %h instr %h, expected pc 14 instr 10", pop_pc[4], pop_instr[4]);
        end
    endtask

    task automatic test_branch_redirect();
        do_reset();
        mem_lat    = 3;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
        wait_issued(2, 10, "br");
        branch_addr_i  = 32'h103;
        branch_taken_i = 1'b1;
        step();
        branch_taken_i = 1'b0;
        n_checks++;
        if (imem_addr_o !== 32'h100) begin n_fail++; $display("[TB] FAIL br_pc: got %h, expected 100", imem_addr_o); end
        n_checks++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL br_flush: got %0b, expected 0", if_valid_o); end
        wait_pops(1, 30, "br");
        n_checks++;
        if (pop_pc.size() !== 1 || pop_pc[0] !== 32'h104 || pop_instr[0] !== 32'h100) begin
            n_fail++; $display("[TB] FAIL br_first: got %0d pops pc %h instr %h, expected 1 pop pc 104 instr 100",
                               pop_pc.size(), pop_pc[0], pop_instr[0]);
        end
        n_checks++;
        if (issued.size() < 3 || issued[2] !== 32'h100) begin
            n_fail++; $display("[TB] FAIL br_refetch: got %h, expected 100", issued[2]);
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        mem_lat    = 1;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
        wait_issued(2, 10, "rs");
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h4) begin
            n_fail++; $display("[TB] FAIL rs_pre: got valid %0b pc %h, expected valid 1 pc 4", if_valid_o, if_pc_o);
        end
        branch_addr_i  = 32'h200;
        branch_taken_i = 1'b1;
        step();
        branch_taken_i = 1'b0;
        n_checks++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rs_flush: got %0b, expected 0", if_valid_o); end
        n_checks++;
        if (imem_addr_o !== 32'h200) begin n_fail++; $display("[TB] FAIL rs_pc: got %h, expected 200", imem_addr_o); end
        n_checks++;
        if (pop_pc.size() !== 0) begin n_fail++; $display("[TB] FAIL rs_pop_ignored: got %0d pops, expected 0", pop_pc.size()); end
        wait_pops(1, 20, "rs");
        n_checks++;
        if (pop_pc.size() < 1 || pop_pc[0] !== 32'h204 || pop_instr[0] !== 32'h200) begin
            n_fail++; $display("[TB] FAIL rs_first: got pc %h instr %h, expected pc 204 instr 200", pop_pc[0], pop_instr[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        mem_lat    = 3;
        data_tag   = 32'hDEAD0000;
        imem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
        wait_issued(1, 10, "rm");
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_req: got %0b, expected 0", imem_req_o); end
        n_checks++;
        if (imem_addr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rm_addr: got %h, expected 0", imem_addr_o); end
        n_checks++;
        if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin
            n_fail++; $display("[TB] FAIL rm_outputs: got valid %0b pc %h instr %h, expected all 0", if_valid_o, if_pc_o, if_instr_o);
        end
        data_tag = '0;
        issued.delete();
        pop_pc.delete();
        pop_instr.delete();
        step();
        rst_n = 1'b1;
        wait_pops(1, 30, "rm");
        n_checks++;
        if (issued.size() < 1 || issued[0] !== 32'h0) begin
            n_fail++; $display("[TB] FAIL rm_restart: got %h, expected 0", issued[0]);
        end
        n_checks++;
        if (pop_pc.size() !== 1 || pop_pc[0] !== 32'h4 || pop_instr[0] !== 32'h0) begin
            n_fail++; $display("[TB] FAIL rm_stale_ignored: got %0d pops pc %h instr %h, expected 1 pop pc 4 instr 0",
                               pop_pc.size(), pop_pc[0], pop_instr[0]);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_freeze();
        test_branch_redirect();
        test_redirect_same_cycle();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
